// File: rtl/pixel_stream_tx_pkg.sv
// Shared types and defaults for the pixel-stream transmitter.
// Frame geometry defaults mirror the pipeline's global frame settings.
package pixel_stream_tx_pkg;

  localparam int unsigned PIXEL_SIZE     = 24;
  localparam int unsigned FRAME_WIDTH    = 640;
  localparam int unsigned FRAME_HEIGHT   = 480;
  localparam int unsigned HBLANK_DEFAULT = 2;
  localparam int unsigned VBLANK_DEFAULT = 3;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StVsync  = 3'd1,
    StActive = 3'd2,
    StHblank = 3'd3,
    StHsync  = 3'd4,
    StVblank = 3'd5
  } tx_state_t;

  // Counter width for a 0..bound-1 range, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned bound);
    return (bound > 1) ? $clog2(bound) : 1;
  endfunction

endpackage

// File: rtl/pixel_stream_tx_raster_counter.sv
// Column/row raster position counter; flags report whether the next inc
// completes the current row or the whole frame.
module raster_counter
  import pixel_stream_tx_pkg::*;
#(
  parameter int unsigned W = 4,
  parameter int unsigned H = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  output logic row_end,
  output logic frame_end
);

  localparam int unsigned ColW = cnt_width(W);
  localparam int unsigned RowW = cnt_width(H);

  logic [ColW-1:0] col_q;
  logic [RowW-1:0] row_q;

  assign row_end   = (col_q == ColW'(W - 1));
  assign frame_end = row_end && (row_q == RowW'(H - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else if (inc) begin
      if (row_end) begin
        col_q <= '0;
        row_q <= frame_end ? '0 : row_q + RowW'(1);
      end else begin
        col_q <= col_q + ColW'(1);
      end
    end
  end

endmodule

// File: rtl/pixel_stream_tx.sv
// Raster transmitter: pulls pixels over valid/ready and emits en/hsync/vsync/data
// slots with sync markers and blanking for the detection pipeline.
module pixel_stream_tx
  import pixel_stream_tx_pkg::*;
#(
  parameter int unsigned FRAME_WIDTH  = pixel_stream_tx_pkg::FRAME_WIDTH,
  parameter int unsigned FRAME_HEIGHT = pixel_stream_tx_pkg::FRAME_HEIGHT,
  parameter int unsigned HBLANK       = HBLANK_DEFAULT,
  parameter int unsigned VBLANK       = VBLANK_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  s_valid,
  input  logic [PIXEL_SIZE-1:0] s_data,
  output logic                  s_ready,
  output logic                  en,
  output logic                  hsync,
  output logic                  vsync,
  output logic [PIXEL_SIZE-1:0] data,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned BlankMax = (HBLANK > VBLANK) ? HBLANK : VBLANK;
  localparam int unsigned BlankW   = cnt_width(BlankMax);

  tx_state_t         state_q;
  logic [BlankW-1:0] blank_q;
  logic              xfer;
  logic              row_end;
  logic              frame_end;

  // State names the decision made this cycle; the slot it produces is on the
  // outputs next cycle, so ACTIVE overlaps the marker slot that precedes a row.
  assign s_ready = (state_q == StActive);
  assign xfer    = s_valid && s_ready;

  raster_counter #(
    .W(FRAME_WIDTH),
    .H(FRAME_HEIGHT)
  ) u_raster_counter (
    .clk      (clk),
    .reset    (reset),
    .inc      (xfer),
    .row_end  (row_end),
    .frame_end(frame_end)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      blank_q    <= '0;
      en         <= 1'b0;
      hsync      <= 1'b0;
      vsync      <= 1'b0;
      data       <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      en         <= 1'b0;
      hsync      <= 1'b0;
      vsync      <= 1'b0;
      data       <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b1;
      case (state_q)
        StIdle: begin
          if (run) begin
            en      <= 1'b1;
            vsync   <= 1'b1;
            state_q <= StActive;
          end else begin
            busy <= 1'b0;
          end
        end
        StVsync: begin
          en      <= 1'b1;
          vsync   <= 1'b1;
          state_q <= StActive;
        end
        StActive: begin
          if (s_valid) begin
            en   <= 1'b1;
            data <= s_data;
            if (frame_end) begin
              if (VBLANK == 0) begin
                frame_done <= 1'b1;
                state_q    <= run ? StVsync : StIdle;
              end else begin
                blank_q <= BlankW'(VBLANK - 1);
                state_q <= StVblank;
              end
            end else if (row_end) begin
              if (HBLANK == 0) begin
                state_q <= StHsync;
              end else begin
                blank_q <= BlankW'(HBLANK - 1);
                state_q <= StHblank;
              end
            end
          end
        end
        StHblank: begin
          if (blank_q == '0) state_q <= StHsync;
          else               blank_q <= blank_q - BlankW'(1);
        end
        StHsync: begin
          en      <= 1'b1;
          hsync   <= 1'b1;
          state_q <= StActive;
        end
        StVblank: begin
          if (blank_q == '0) begin
            frame_done <= 1'b1;
            state_q    <= run ? StVsync : StIdle;
          end else begin
            blank_q <= blank_q - BlankW'(1);
          end
        end
        default: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Directed bench for pixel_stream_tx: W=4 H=3 with HBLANK=2/VBLANK=3, plus a
// second instance with zero-length blanking.
module tb_pixel_stream_tx;
  import pixel_stream_tx_pkg::*;

  localparam int PB = 24'h123400;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset, run, s_valid, s_ready, en, hsync, vsync, busy, frame_done;
  logic [PIXEL_SIZE-1:0] s_data, data;
  logic                  reset_z, run_z, s_ready_z, en_z, hsync_z, vsync_z, busy_z, fd_z;
  logic [PIXEL_SIZE-1:0] s_data_z, data_z;
  int                    src_idx, src_idx_z;

  pixel_stream_tx #(
    .FRAME_WIDTH(4), .FRAME_HEIGHT(3), .HBLANK(2), .VBLANK(3)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .en(en), .hsync(hsync), .vsync(vsync), .data(data),
    .busy(busy), .frame_done(frame_done)
  );

  pixel_stream_tx #(
    .FRAME_WIDTH(4), .FRAME_HEIGHT(3), .HBLANK(0), .VBLANK(0)
  ) dut_z (
    .clk(clk), .reset(reset_z), .run(run_z), .s_valid(1'b1), .s_data(s_data_z),
    .s_ready(s_ready_z), .en(en_z), .hsync(hsync_z), .vsync(vsync_z), .data(data_z),
    .busy(busy_z), .frame_done(fd_z)
  );

  // Sources emit PB+n for the n-th pixel since their last reset.
  assign s_data   = PIXEL_SIZE'(PB + src_idx);
  assign s_data_z = PIXEL_SIZE'(PB + src_idx_z);
  always @(posedge clk) begin
    if (reset) src_idx <= 0;
    else if (s_valid && s_ready) src_idx <= src_idx + 1;
    if (reset_z) src_idx_z <= 0;
    else if (s_ready_z) src_idx_z <= src_idx_z + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Output monitor for dut, with a downstream x/y/frame counter model.
  int cyc = 0, both_hi = 0, en_slots = 0;
  int vs_t[$], fd_t[$], pix_q[$], pix_t[$];
  int ds_frame = 0, ds_y = 0, ds_ymax = 0;
  always @(posedge clk) begin
    #1;
    cyc++;
    if (hsync && vsync) both_hi++;
    if (en) en_slots++;
    if (en && vsync) begin
      vs_t.push_back(cyc);
      ds_frame++;
      ds_y = 0;
    end else if (en && hsync) begin
      ds_y++;
    end else if (en) begin
      pix_q.push_back(int'(data));
      pix_t.push_back(cyc);
      if (ds_y > ds_ymax) ds_ymax = ds_y;
    end
    if (frame_done) fd_t.push_back(cyc);
  end

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1000;
  endfunction

  task automatic clear_mon();
    vs_t.delete(); fd_t.delete(); pix_q.delete(); pix_t.delete();
    en_slots = 0; ds_ymax = 0;
  endtask

  task automatic chk_pixels(input string name, input int n);
    int bad = 0;
    if (pix_q.size() != n) bad++;
    else for (int i = 0; i < n; i++) if (pix_q[i] != PB + i) bad++;
    chk(name, bad, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear_mon();
  endtask

  task automatic pulse_run();
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic wait_fd(input int n, input string name);
    int t = 0;
    while (fd_t.size() < n && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (fd_t.size() < n) chk({name, "_timeout"}, 0, 1);
  endtask

  typedef struct {
    logic        rst;
    logic        run;
    logic [5:0]  flags;  // {en, hsync, vsync, s_ready, busy, frame_done}
    logic [23:0] data;
  } vec_t;

  vec_t vecs[24];
  vec_t v;
  int   kind, pidx;
  int   exp_kind[16];
  int   t;

  initial begin
    reset = 1'b1; run = 1'b0; s_valid = 1'b1;
    reset_z = 1'b1; run_z = 1'b0;

    vecs[0]  = '{1, 0, 6'b000000, 24'h0};
    vecs[1]  = '{0, 1, 6'b101110, 24'h0};
    vecs[2]  = '{0, 0, 6'b100110, PB + 0};
    vecs[3]  = '{0, 0, 6'b100110, PB + 1};
    vecs[4]  = '{0, 0, 6'b100110, PB + 2};
    vecs[5]  = '{0, 0, 6'b100010, PB + 3};
    vecs[6]  = '{0, 0, 6'b000010, 24'h0};
    vecs[7]  = '{0, 0, 6'b000010, 24'h0};
    vecs[8]  = '{0, 0, 6'b110110, 24'h0};
    vecs[9]  = '{0, 0, 6'b100110, PB + 4};
    vecs[10] = '{0, 0, 6'b100110, PB + 5};
    vecs[11] = '{0, 0, 6'b100110, PB + 6};
    vecs[12] = '{0, 0, 6'b100010, PB + 7};
    vecs[13] = '{0, 0, 6'b000010, 24'h0};
    vecs[14] = '{0, 0, 6'b000010, 24'h0};
    vecs[15] = '{0, 0, 6'b110110, 24'h0};
    vecs[16] = '{0, 0, 6'b100110, PB + 8};
    vecs[17] = '{0, 0, 6'b100110, PB + 9};
    vecs[18] = '{0, 0, 6'b100110, PB + 10};
    vecs[19] = '{0, 0, 6'b100010, PB + 11};
    vecs[20] = '{0, 0, 6'b000010, 24'h0};
    vecs[21] = '{0, 0, 6'b000010, 24'h0};
    vecs[22] = '{0, 0, 6'b000011, 24'h0};
    vecs[23] = '{0, 0, 6'b000000, 24'h0};

    for (int i = 0; i < 24; i++) begin
      v = vecs[i];
      @(negedge clk);
      reset = v.rst;
      run   = v.run;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i),
          int'({en, hsync, vsync, s_ready, busy, frame_done, data}),
          int'({v.flags, v.data}));
    end

    // Back-to-back frames with run held high.
    do_reset();
    t = ds_frame;
    @(negedge clk);
    run = 1'b1;
    for (int i = 0; i < 100 && vs_t.size() < 2; i++) @(negedge clk);
    run = 1'b0;
    wait_fd(2, "b2b");
    chk("b2b_vsync_gap", qat(vs_t, 1) - qat(vs_t, 0), 22);
    chk("b2b_fd_pos", qat(fd_t, 0) - qat(vs_t, 0) + 1, 22);
    chk_pixels("b2b_pixels", 24);
    chk("ds_frame_inc", ds_frame - t, 2);
    chk("ds_ymax", ds_ymax, 2);
    chk("b2b_en_slots", en_slots, 30);

    // Source stall of 3 cycles after pixel (1,2).
    do_reset();
    pulse_run();
    for (int i = 0; i < 100 && src_idx != 7; i++) @(negedge clk);
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    s_valid = 1'b1;
    wait_fd(1, "stall");
    chk("stall_period", qat(fd_t, 0) - qat(vs_t, 0) + 1, 25);
    chk("stall_gap", qat(pix_t, 7) - qat(pix_t, 6), 4);
    chk_pixels("stall_pixels", 12);
    chk("stall_en_slots", en_slots, 15);

    // Reset during row 1, then a clean frame.
    do_reset();
    pulse_run();
    for (int i = 0; i < 100 && src_idx != 5; i++) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_reset_outputs",
        int'({en, hsync, vsync, s_ready, busy, frame_done, data}), 0);
    @(negedge clk);
    reset = 1'b0;
    clear_mon();
    pulse_run();
    wait_fd(1, "after_reset");
    chk("after_reset_period", qat(fd_t, 0) - qat(vs_t, 0) + 1, 22);
    chk("after_reset_vsyncs", vs_t.size(), 1);
    chk_pixels("after_reset_pixels", 12);
    chk("never_both_sync", both_hi, 0);

    // Zero-length blanking instance: fully packed frame.
    exp_kind = '{1, 3, 3, 3, 3, 2, 3, 3, 3, 3, 2, 3, 3, 3, 3, 0};
    @(negedge clk);
    reset_z = 1'b0;
    @(negedge clk);
    run_z = 1'b1;
    pidx = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      run_z = 1'b0;
      kind = vsync_z ? 1 : hsync_z ? 2 : en_z ? 3 : 0;
      chk($sformatf("z_slot%0d", i + 1),
          int'({kind[1:0], fd_z, busy_z, hsync_z & vsync_z, data_z}),
          int'({exp_kind[i][1:0], (i == 14), (i < 15), 1'b0,
                (exp_kind[i] == 3) ? PIXEL_SIZE'(PB + pidx) : PIXEL_SIZE'(0)}));
      if (exp_kind[i] == 3) pidx++;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
